// File: rtl/mips_dp_mem.sv
// Dual-port instruction/data store for the MIPS core: port A read-only fetch, port B byte-enabled read/write.
// Reads are pipelined over RD_LAT cycles and accept one request per cycle per port; there is no backpressure.
module mips_dp_mem #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a_req,
  input  logic [ADDR_W-1:0]     i_a_addr,
  output logic [DATA_W-1:0]     o_a_rdata,
  output logic                  o_a_rvalid,
  output logic                  o_a_err,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [DATA_W/8-1:0]   i_b_be,
  input  logic [ADDR_W-1:0]     i_b_addr,
  input  logic [DATA_W-1:0]     i_b_wdata,
  output logic [DATA_W-1:0]     o_b_rdata,
  output logic                  o_b_rvalid,
  output logic                  o_b_err
);

  localparam int BW    = DATA_W / 8;
  localparam int OFF_W = $clog2(BW);
  localparam int IDX_W = $clog2(DEPTH);

  if ((RD_LAT < 1) || (RD_LAT > 4) || ((DATA_W % 8) != 0) || (DEPTH < 2) ||
      ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
    $fatal(1, "mips_dp_mem: illegal parameters (RD_LAT=%0d DATA_W=%0d DEPTH=%0d)",
           RD_LAT, DATA_W, DEPTH);
  end

  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] lo_mask;
    lo_mask = ADDR_W'(BW - 1);
    return ((addr & lo_mask) != '0) || ((addr >> (OFF_W + IDX_W)) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> OFF_W);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BW-1:0]     be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < BW; k++) begin
      if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [RD_LAT-1:0] a_vld_q, a_vld_d, a_err_q, a_err_d;
  logic [RD_LAT-1:0] b_vld_q, b_vld_d, b_err_q, b_err_d;
  logic [DATA_W-1:0] a_dat_q [RD_LAT];
  logic [DATA_W-1:0] a_dat_d [RD_LAT];
  logic [DATA_W-1:0] b_dat_q [RD_LAT];
  logic [DATA_W-1:0] b_dat_d [RD_LAT];
  logic [IDX_W-1:0]  b_idx_q [RD_LAT];
  logic [IDX_W-1:0]  b_idx_d [RD_LAT];

  logic             a_bad, b_bad, b_rd, b_wr, fwd;
  logic [IDX_W-1:0] a_idx, b_idx;

  always_comb begin
    a_bad = addr_bad(i_a_addr);
    a_idx = idx_of(i_a_addr);
    b_bad = addr_bad(i_b_addr);
    b_idx = idx_of(i_b_addr);
    b_rd  = i_b_req && !i_b_we;
    b_wr  = i_b_req && i_b_we && !b_bad;
    fwd   = 1'b0;

    a_vld_d = a_vld_q;
    a_err_d = a_err_q;
    a_dat_d = a_dat_q;
    b_vld_d = b_vld_q;
    b_err_d = b_err_q;
    b_dat_d = b_dat_q;
    b_idx_d = b_idx_q;

    a_vld_d[0] = i_a_req;
    a_err_d[0] = i_a_req && a_bad;
    if (i_a_req) a_dat_d[0] = a_bad ? '0 : mem_q[a_idx];

    b_vld_d[0] = b_rd;
    b_err_d[0] = i_b_req && b_bad;
    b_idx_d[0] = b_idx;
    if (b_rd) b_dat_d[0] = b_bad ? '0 : mem_q[b_idx];

    // Data stages only load on a valid read so rdata holds between reads.
    for (int i = 1; i < RD_LAT; i++) begin
      a_vld_d[i] = a_vld_q[i-1];
      a_err_d[i] = a_err_q[i-1];
      if (a_vld_q[i-1]) a_dat_d[i] = a_dat_q[i-1];

      b_vld_d[i] = b_vld_q[i-1];
      b_err_d[i] = b_err_q[i-1];
      b_idx_d[i] = b_idx_q[i-1];
      fwd = (WR_FIRST != 0) && b_wr && b_vld_q[i-1] && !b_err_q[i-1] &&
            (b_idx_q[i-1] == b_idx);
      if (b_vld_q[i-1])
        b_dat_d[i] = fwd ? merge(b_dat_q[i-1], i_b_wdata, i_b_be) : b_dat_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_vld_q <= '0;
      a_err_q <= '0;
      b_vld_q <= '0;
      b_err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        a_dat_q[i] <= '0;
        b_dat_q[i] <= '0;
        b_idx_q[i] <= '0;
      end
    end else begin
      a_vld_q <= a_vld_d;
      a_err_q <= a_err_d;
      a_dat_q <= a_dat_d;
      b_vld_q <= b_vld_d;
      b_err_q <= b_err_d;
      b_dat_q <= b_dat_d;
      b_idx_q <= b_idx_d;
    end
  end

  // Array contents survive reset; writes are simply blocked while it is held.
  always_ff @(posedge i_clk) begin
    if (b_wr && !i_rst) begin
      for (int k = 0; k < BW; k++) begin
        if (i_b_be[k]) mem_q[b_idx][k*8 +: 8] <= i_b_wdata[k*8 +: 8];
      end
    end
  end

  assign o_a_rvalid = a_vld_q[RD_LAT-1];
  assign o_a_err    = a_err_q[RD_LAT-1];
  assign o_a_rdata  = a_dat_q[RD_LAT-1];
  assign o_b_rvalid = b_vld_q[RD_LAT-1];
  assign o_b_err    = b_err_q[RD_LAT-1];
  assign o_b_rdata  = b_dat_q[RD_LAT-1];

endmodule
